m_seq_sync: RTL and testbench

//  Downstream of dec_qpsk: consumes its 31-chip shift buffer (buff_wr) each chip and correlates it against the m-sequence.

---
 rtl/m_seq_pkg.sv | 36 +++
 rtl/m_seq_popcount.sv | 34 +++
 rtl/m_seq_sync.sv | 174 +++++++++++++++++
 tb/tb_m_seq_sync.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_seq_pkg.sv
// Shared constants, state encoding and parameter legality check for the
// m-sequence code-phase synchroniser (m_seq_sync).
package m_seq_pkg;

    localparam int SEQ_LEN  = 31;
    localparam logic [SEQ_LEN-1:0] TEMPLATE = 31'b0110010011111011100010101101000;

    localparam int THRESH   = 3;
    localparam int LOCK_CNT = 3;
    localparam int MISS_MAX = 2;

    localparam int PHASE_W  = 5;
    localparam int CNT_W    = 2;

    localparam logic [PHASE_W-1:0] SEQ_LEN_V  = PHASE_W'(SEQ_LEN);
    localparam logic [PHASE_W-1:0] THRESH_V   = PHASE_W'(THRESH);
    localparam logic [PHASE_W-1:0] HALF_V     = PHASE_W'(SEQ_LEN / 2);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0]   LOCK_CNT_V = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]   MISS_MAX_V = CNT_W'(MISS_MAX);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } sync_state_t;

    // Positive and inverted peaks only stay mutually exclusive while the
    // mismatch threshold is below half the code length.
    function automatic bit thresh_is_legal(input int t);
        return (t >= 0) && (t < 16);
    endfunction

    localparam bit THRESH_LEGAL = thresh_is_legal(THRESH);

endpackage

// File: rtl/m_seq_popcount.sv
// Combinational population count of a SEQ_LEN-bit word, built as a
// balanced adder tree (pairs -> nibbles -> ... -> 5-bit result).
module m_seq_popcount
    import m_seq_pkg::*;
(
    input  logic [SEQ_LEN-1:0] data,
    output logic [PHASE_W-1:0] count
);

    logic [31:0] padded;
    logic [1:0]  lvl1 [16];
    logic [2:0]  lvl2 [8];
    logic [3:0]  lvl3 [4];
    logic [4:0]  lvl4 [2];

    // Sum adjacent pairs level by level; the top bit of the padded word is 0.
    always_comb begin
        padded = {1'b0, data};
        for (int i = 0; i < 16; i++) begin
            lvl1[i] = {1'b0, padded[2*i]} + {1'b0, padded[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            lvl2[i] = {1'b0, lvl1[2*i]} + {1'b0, lvl1[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl3[i] = {1'b0, lvl2[2*i]} + {1'b0, lvl2[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl4[i] = {1'b0, lvl3[2*i]} + {1'b0, lvl3[2*i+1]};
        end
        count = lvl4[0] + lvl4[1];
    end

endmodule

// File: rtl/m_seq_sync.sv
// m-sequence code-phase synchroniser: correlates the dec_qpsk chip buffer
// against TEMPLATE, acquires and tracks code phase, emits one despread bit
// per code period while locked.
// Optional feature macro: M_SYNC_STATS_EN adds saturating miss_total and
// bit_total counters and their output ports.
module m_seq_sync
    import m_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEQ_LEN-1:0] buff_wr,
    input  logic               chip_valid,
    output logic               peak,
    output logic               bit_out,
    output logic               bit_valid,
    output logic               locked,
    output logic [PHASE_W-1:0] phase
`ifdef M_SYNC_STATS_EN
    ,
    output logic [15:0]        miss_total,
    output logic [15:0]        bit_total
`endif
);

    if (!THRESH_LEGAL) begin : g_thresh_check
        $error("m_seq_sync: THRESH must be below 16");
    end

    logic [PHASE_W-1:0] dist_raw;
    logic [PHASE_W-1:0] dist_q;
    logic [PHASE_W-1:0] dist_inv;
    logic               v1;
    logic               pos;
    logic               neg;
    logic               match;
    logic               expected;

    sync_state_t        state;
    sync_state_t        state_d;
    logic [PHASE_W-1:0] phase_d;
    logic [CNT_W-1:0]   hits;
    logic [CNT_W-1:0]   hits_d;
    logic [CNT_W-1:0]   misses;
    logic [CNT_W-1:0]   misses_d;
    logic               peak_d;
    logic               bit_valid_d;
    logic               bit_out_d;

    m_seq_popcount u_popcount (
        .data  (buff_wr ^ TEMPLATE),
        .count (dist_raw)
    );

    assign dist_inv = SEQ_LEN_V - dist_q;
    assign pos      = (dist_q <= THRESH_V);
    assign neg      = (dist_inv <= THRESH_V);
    assign match    = pos | neg;
    assign expected = v1 && (phase == LAST_PHASE);
    assign locked   = (state == LOCK);

    // Stage 1: register the Hamming distance and its chip-valid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dist_q <= '0;
            v1     <= 1'b0;
        end else begin
            dist_q <= dist_raw;
            v1     <= chip_valid;
        end
    end

    // Stage 2: state, phase, counters and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            phase     <= '0;
            hits      <= '0;
            misses    <= '0;
            peak      <= 1'b0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
        end else begin
            state     <= state_d;
            phase     <= phase_d;
            hits      <= hits_d;
            misses    <= misses_d;
            peak      <= peak_d;
            bit_valid <= bit_valid_d;
            bit_out   <= bit_out_d;
        end
    end

    // Next-state logic; everything holds and strobes stay low on a bubble.
    // The miss that drops lock suppresses bit_valid so no strobe coincides
    // with the return to SEARCH.
    always_comb begin
        state_d     = state;
        phase_d     = phase;
        hits_d      = hits;
        misses_d    = misses;
        peak_d      = 1'b0;
        bit_valid_d = 1'b0;
        bit_out_d   = bit_out;
        if (v1) begin
            phase_d = (phase == LAST_PHASE) ? '0 : phase + 1'b1;
            case (state)
                SEARCH: begin
                    if (match) begin
                        phase_d = '0;
                        hits_d  = CNT_W'(1);
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (expected) begin
                        if (match) begin
                            peak_d = 1'b1;
                            hits_d = hits + 1'b1;
                            if (hits_d == LOCK_CNT_V) begin
                                state_d  = LOCK;
                                misses_d = '0;
                            end
                        end else begin
                            state_d = SEARCH;
                        end
                    end
                end
                LOCK: begin
                    if (expected) begin
                        if (match) begin
                            peak_d      = 1'b1;
                            misses_d    = '0;
                            bit_valid_d = 1'b1;
                            bit_out_d   = (dist_q > HALF_V);
                        end else begin
                            misses_d = misses + 1'b1;
                            if (misses_d == MISS_MAX_V) begin
                                state_d = SEARCH;
                            end else begin
                                bit_valid_d = 1'b1;
                                bit_out_d   = (dist_q > HALF_V);
                            end
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

`ifdef M_SYNC_STATS_EN
    logic miss_event;

    assign miss_event = expected && (state == LOCK) && !match;

    // Saturating counters of on-phase misses in lock and emitted bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_total <= '0;
            bit_total  <= '0;
        end else begin
            if (miss_event && (miss_total != 16'hFFFF)) begin
                miss_total <= miss_total + 16'd1;
            end
            if (bit_valid_d && (bit_total != 16'hFFFF)) begin
                bit_total <= bit_total + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_seq_sync.sv
// Self-checking bench for m_seq_sync: directed scenarios plus randomized
// chip streams compared every cycle against a behavioural model.
// Honours M_SYNC_STATS_EN when defined for the build.
module tb_m_seq_sync;
    import m_seq_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [SEQ_LEN-1:0] buff_wr = '0;
    logic               chip_valid = 1'b0;
    logic               peak;
    logic               bit_out;
    logic               bit_valid;
    logic               locked;
    logic [PHASE_W-1:0] phase;
`ifdef M_SYNC_STATS_EN
    logic [15:0]        miss_total;
    logic [15:0]        bit_total;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;

    logic [SEQ_LEN-1:0] rot = TEMPLATE;

    m_seq_sync dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buff_wr    (buff_wr),
        .chip_valid (chip_valid),
        .peak       (peak),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .locked     (locked),
        .phase      (phase)
`ifdef M_SYNC_STATS_EN
        ,
        .miss_total (miss_total),
        .bit_total  (bit_total)
`endif
    );

    // Chip clock, 10 time units per chip.
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit pend_v;
    int pend_dist;
    int m_mode;
    int m_age;
    int m_hits;
    int m_miss;
    int m_miss_total;
    int m_bit_total;
    bit e_peak;
    bit e_bv;
    bit e_bo;

    task automatic modelClear();
        pend_v = 0; pend_dist = 0;
        m_mode = 0; m_age = 0; m_hits = 0; m_miss = 0;
        m_miss_total = 0; m_bit_total = 0;
        e_peak = 0; e_bv = 0; e_bo = 0;
    endtask

    // One accepted chip; m_mode 0 = searching, 1 = verifying, 2 = locked.
    task automatic modelChip(input int d);
        bit is_match;
        bit on_phase;
        is_match = (d <= THRESH) || ((SEQ_LEN - d) <= THRESH);
        on_phase = (m_age == SEQ_LEN - 1);
        m_age = (m_age + 1) % SEQ_LEN;
        if (m_mode == 0) begin
            if (is_match) begin
                m_mode = 1; m_age = 0; m_hits = 1;
            end
        end else if (on_phase) begin
            if (m_mode == 1) begin
                if (is_match) begin
                    e_peak = 1;
                    m_hits++;
                    if (m_hits >= LOCK_CNT) begin
                        m_mode = 2; m_miss = 0;
                    end
                end else begin
                    m_mode = 0;
                end
            end else begin
                if (is_match) begin
                    e_peak = 1; m_miss = 0;
                end else begin
                    m_miss++; m_miss_total++;
                end
                if (m_miss >= MISS_MAX) begin
                    m_mode = 0;
                end else begin
                    e_bv = 1; e_bo = (d > SEQ_LEN / 2); m_bit_total++;
                end
            end
        end
    endtask

    // Model sees each chip one edge after it is presented, like the DUT.
    initial begin
        modelClear();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                modelClear();
            end else begin
                e_peak = 0; e_bv = 0;
                if (pend_v) modelChip(pend_dist);
                pend_v = chip_valid;
                pend_dist = $countones(buff_wr ^ TEMPLATE);
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                checkOutput("peak", 32'(peak), 32'(e_peak));
                checkOutput("bit_valid", 32'(bit_valid), 32'(e_bv));
                checkOutput("bit_out", 32'(bit_out), 32'(e_bo));
                checkOutput("locked", 32'(locked), 32'(m_mode == 2));
                checkOutput("phase", 32'(phase), 32'(m_age));
`ifdef M_SYNC_STATS_EN
                checkOutput("miss_total", 32'(miss_total), 32'((m_miss_total > 65535) ? 65535 : m_miss_total));
                checkOutput("bit_total", 32'(bit_total), 32'((m_bit_total > 65535) ? 65535 : m_bit_total));
`endif
            end
        end
    end

    // Strobe bookkeeping used by the hand-computed expectations.
    int n_peak = 0;
    int n_bv = 0;
    int n_lock = 0;
    int last_peak_cyc = 0;
    int prev_peak_cyc = 0;
    int first_peak_cyc = -1;
    logic last_bo = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (peak === 1'b1) begin
                if (first_peak_cyc < 0) first_peak_cyc = cyc;
                n_peak++;
                prev_peak_cyc = last_peak_cyc;
                last_peak_cyc = cyc;
            end
            if (bit_valid === 1'b1) begin
                n_bv++;
                last_bo = bit_out;
            end
            if (locked === 1'b1) n_lock++;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [SEQ_LEN-1:0] errMask(input int k);
        logic [SEQ_LEN-1:0] m;
        m = '0;
        for (int t = 0; (t < 500) && ($countones(m) < k); t++) begin
            m[$urandom_range(SEQ_LEN - 1, 0)] = 1'b1;
        end
        return m;
    endfunction

    task automatic applyStimulus(input int errs, input bit inv, input bit valid);
        @(negedge clk);
        buff_wr = rot ^ errMask(errs) ^ (inv ? {SEQ_LEN{1'b1}} : {SEQ_LEN{1'b0}});
        chip_valid = valid;
        if (valid) rot = {rot[SEQ_LEN-2:0], rot[SEQ_LEN-1]};
    endtask

    task automatic applyRaw(input logic [SEQ_LEN-1:0] b, input bit valid);
        @(negedge clk);
        buff_wr = b;
        chip_valid = valid;
    endtask

    task automatic dropReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        chip_valid = 1'b0;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int snap_p;
    int snap_b;
    int snap_l;
    int drive_cyc;
    logic [SEQ_LEN-1:0] lfsr;
    bit inv;
    bit valid;
    int errs;
    int vprob;

    initial begin
        @(negedge clk);
        cmp_en = 1'b1;
        #1;
        checkOutput("reset_peak", 32'(peak), 32'd0);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        checkOutput("reset_phase", 32'(phase), 32'd0);
        releaseReset();

        // 1: clean rotating template, continuous chips
        $display("[TB] scenario 1: clean acquisition");
        snap_p = n_peak; snap_b = n_bv;
        for (int n = 0; n < 5 * SEQ_LEN; n++) begin
            applyStimulus(0, 0, 1);
            if (n == SEQ_LEN) drive_cyc = cyc;
        end
        repeat (3) applyStimulus(0, 0, 0);
        #1;
        checkOutput("t1_first_latency", 32'(first_peak_cyc - drive_cyc), 32'd2);
        checkOutput("t1_peaks", 32'(n_peak - snap_p), 32'd4);
        checkOutput("t1_bits", 32'(n_bv - snap_b), 32'd2);
        checkOutput("t1_gap", 32'(last_peak_cyc - prev_peak_cyc), 32'd31);
        checkOutput("t1_locked", 32'(locked), 32'd1);
        checkOutput("t1_bit_out", 32'(last_bo), 32'd0);

        // 2: inverted period while locked
        $display("[TB] scenario 2: polarity flip");
        snap_p = n_peak; snap_b = n_bv;
        repeat (SEQ_LEN) applyStimulus(0, 1, 1);
        repeat (3) applyStimulus(0, 0, 0);
        #1;
        checkOutput("t2_peaks", 32'(n_peak - snap_p), 32'd1);
        checkOutput("t2_bits", 32'(n_bv - snap_b), 32'd1);
        checkOutput("t2_bit_out", 32'(last_bo), 32'd1);
        checkOutput("t2_locked", 32'(locked), 32'd1);

        // 3: tolerable errors, then two heavily corrupted periods
        $display("[TB] scenario 3: chip errors");
        snap_p = n_peak; snap_b = n_bv;
        repeat (2 * SEQ_LEN) applyStimulus(3, 0, 1);
        repeat (2 * SEQ_LEN) applyStimulus(7, 0, 1);
        repeat (3) applyStimulus(0, 0, 0);
        #1;
        checkOutput("t3_peaks", 32'(n_peak - snap_p), 32'd2);
        checkOutput("t3_bits", 32'(n_bv - snap_b), 32'd3);
        checkOutput("t3_locked", 32'(locked), 32'd0);

        // 4: LFSR noise never locks
        $display("[TB] scenario 4: random chips");
        snap_l = n_lock; snap_b = n_bv;
        lfsr = SEQ_LEN'($urandom) | 31'd1;
        repeat (2000) begin
            lfsr = {lfsr[SEQ_LEN-2:0], lfsr[30] ^ lfsr[27]};
            applyRaw(lfsr, 1);
        end
        repeat (3) applyRaw(lfsr, 0);
        #1;
        checkOutput("t4_lock_cycles", 32'(n_lock - snap_l), 32'd0);
        checkOutput("t4_bits", 32'(n_bv - snap_b), 32'd0);

        // 5: chip_valid every other cycle
        $display("[TB] scenario 5: gapped chips");
        dropReset();
        releaseReset();
        rot = TEMPLATE;
        snap_p = n_peak;
        repeat (3 * SEQ_LEN) begin
            applyStimulus(0, 0, 1);
            applyStimulus(0, 0, 0);
        end
        repeat (3) applyStimulus(0, 0, 0);
        #1;
        checkOutput("t5_peaks", 32'(n_peak - snap_p), 32'd2);
        checkOutput("t5_gap", 32'(last_peak_cyc - prev_peak_cyc), 32'd62);
        checkOutput("t5_locked", 32'(locked), 32'd1);

        // 6: asynchronous reset while locked, then relock
        $display("[TB] scenario 6: reset while locked");
        dropReset();
        #1;
        checkOutput("t6_rst_locked", 32'(locked), 32'd0);
        checkOutput("t6_rst_phase", 32'(phase), 32'd0);
        checkOutput("t6_rst_peak", 32'(peak), 32'd0);
        checkOutput("t6_rst_bit_valid", 32'(bit_valid), 32'd0);
        checkOutput("t6_rst_bit_out", 32'(bit_out), 32'd0);
`ifdef M_SYNC_STATS_EN
        checkOutput("t6_rst_bit_total", 32'(bit_total), 32'd0);
`endif
        releaseReset();
        snap_p = n_peak;
        repeat (3 * SEQ_LEN) applyStimulus(0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0);
        #1;
        checkOutput("t6_peaks", 32'(n_peak - snap_p), 32'd2);
        checkOutput("t6_relocked", 32'(locked), 32'd1);

        // 7: randomized stream with errors, gaps, flips, slips and resets
        $display("[TB] scenario 7: randomized stream");
        inv = 0;
        vprob = 100;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) vprob = $urandom_range(100, 40);
            if ($urandom_range(799) == 0) begin
                dropReset();
                releaseReset();
            end else begin
                valid = ($urandom_range(99) < vprob);
                if (valid && (rot == TEMPLATE) && ($urandom_range(3) == 0)) inv = ~inv;
                errs = ($urandom_range(9) < 7) ? 0 : $urandom_range(6, 1);
                if ($urandom_range(599) == 0) rot = {rot[SEQ_LEN-2:0], rot[SEQ_LEN-1]};
                applyStimulus(errs, inv, valid);
            end
        end
        repeat (4) applyStimulus(0, 0, 0);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
